// File: rtl/gpio_pio_pkg.sv
// gpio_pio_pkg: register map and edge-select constants for the Avalon-MM GPIO
package gpio_pio_pkg;
    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: per-bit input synchroniser with delayed copy and rise/fall detect
//  clk, reset_n : clock, synchronous active-low reset
//  gpio_in      : asynchronous pins
//  sync_in      : last synchroniser stage
//  rise, fall   : sync_in vs its one-clock-delayed copy
module gpio_sync_edge #(
    parameter int WIDTH       = 14,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0] prev;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chain <= '0;
            prev  <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], gpio_in};
            prev  <= chain[SYNC_STAGES-1];
        end
    end
    assign sync_in = chain[SYNC_STAGES-1];
    assign rise    = sync_in & ~prev;
    assign fall    = ~sync_in & prev;
endmodule

// File: rtl/avmm_gpio_pio.sv
// avmm_gpio_pio: Avalon-MM bidirectional GPIO with set/clear, edge capture and masked irq
//  clk, reset_n                       : clock, synchronous active-low reset
//  address, chipselect, write_n,
//  writedata, readdata                : zero-wait slave, combinational read
//  gpio_in, gpio_out, gpio_oe         : pins in, output data, output enable (=direction)
//  irq                                : |(edge_cap & mask)
module avmm_gpio_pio
    import gpio_pio_pkg::*;
#(
    parameter int               WIDTH       = 14,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '1,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);
    localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);
    logic [WIDTH-1:0] data_out, dir, mask, edge_cap, sync_in, rise, fall, edge_sel, cap, wd, rd;
    logic [2:0] arm_cnt;
    logic wr, armed;
    gpio_sync_edge #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .reset_n(reset_n), .gpio_in(gpio_in),
        .sync_in(sync_in), .rise(rise), .fall(fall)
    );
    assign wr    = chipselect & ~write_n;
    assign wd    = writedata[WIDTH-1:0];
    assign armed = arm_cnt == ARM_MAX;
    always_comb begin
        edge_sel = EDGE_TYPE == EDGE_RISE ? rise : EDGE_TYPE == EDGE_FALL ? fall : rise | fall;
        // inputs-only capture, held off until the synchroniser has filled after reset
        cap = armed ? edge_sel & ~dir : '0;
        rd  = address == ADDR_DATA ? (data_out & dir) | (sync_in & ~dir) :
              address == ADDR_DIR  ? dir :
              address == ADDR_MASK ? mask :
              address == ADDR_EDGE ? edge_cap : '0;
        readdata = 32'(rd);
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out <= RESET_OUT;
            dir      <= RESET_DIR;
            mask     <= '0;
            edge_cap <= '0;
            arm_cnt  <= '0;
        end else begin
            arm_cnt  <= armed ? arm_cnt : arm_cnt + 3'd1;
            // a new edge beats a same-cycle write-1-to-clear
            edge_cap <= (edge_cap & ~((wr && address == ADDR_EDGE) ? wd : '0)) | cap;
            data_out <= !wr                   ? data_out :
                        address == ADDR_DATA   ? wd :
                        address == ADDR_OUTSET ? data_out | wd :
                        address == ADDR_OUTCLR ? data_out & ~wd : data_out;
            if (wr && address == ADDR_DIR) dir <= wd;
            if (wr && address == ADDR_MASK) mask <= wd;
        end
    end
    assign gpio_out = data_out;
    assign gpio_oe  = dir;
    assign irq      = |(edge_cap & mask);
endmodule
